triangle_raster_engine: RTL and testbench

//  Parametrised triangle fill engine for the VGA framebuffer path. Accepts one triangle
//  (3 vertices + colour) per command, scans only its clipped bounding box, and streams

---
 rtl/triangle_raster_engine_if.sv | 35 +++
 rtl/triangle_raster_engine.sv | 172 +++++++++++++++++
 tb/tb_triangle_raster_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_raster_engine_if.sv
// Command and pixel-stream bundle for the triangle fill engine.
// The host (master) issues triangles and sinks pixels; the engine is the slave.
interface triangle_raster_engine_if #(
  parameter int XW = 11,
  parameter int YW = 11,
  parameter int CW = 12
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [XW-1:0]        v0x;
  logic [XW-1:0]        v1x;
  logic [XW-1:0]        v2x;
  logic [YW-1:0]        v0y;
  logic [YW-1:0]        v1y;
  logic [YW-1:0]        v2y;
  logic [CW-1:0]        cmd_color;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [XW-1:0]        pix_x;
  logic [YW-1:0]        pix_y;
  logic [CW-1:0]        pix_color;
  logic                 busy;
  logic                 done;
  logic [XW+YW-1:0]     pix_count;

  modport master (
    output cmd_valid, v0x, v1x, v2x, v0y, v1y, v2y, cmd_color, pix_ready,
    input  cmd_ready, pix_valid, pix_x, pix_y, pix_color, busy, done, pix_count
  );

  modport slave (
    input  cmd_valid, v0x, v1x, v2x, v0y, v1y, v2y, cmd_color, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_color, busy, done, pix_count
  );
endinterface

// File: rtl/triangle_raster_engine.sv
// Triangle fill engine: scans the screen-clipped bounding box of one triangle per
// command and streams inside pixels (edge-function test, winding independent).
module triangle_raster_engine #(
  parameter int XW    = 11,
  parameter int YW    = 11,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CW    = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  triangle_raster_engine_if.slave    bus
);

  localparam int EW = XW + YW + 3;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef logic signed [EW-1:0] e_t;
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [XW-1:0]   v0x_reg, v1x_reg, v2x_reg;
  logic [YW-1:0]   v0y_reg, v1y_reg, v2y_reg;
  logic [CW-1:0]   color_reg;
  logic [XW-1:0]   x_reg, xmin_reg, xmax_reg;
  logic [YW-1:0]   y_reg, ymax_reg;
  logic [XW+YW-1:0] count_reg;

  logic [XW-1:0]   xlo, xhi;
  logic [YW-1:0]   ylo, yhi;
  e_t              area, e0, e1, e2;
  logic            pt_inside, at_last, advance;

  // Zero-extended operands keep the differences exact; the products fit in EW bits.
  function automatic e_t edge_fn(
    input logic [XW-1:0] ax, input logic [YW-1:0] ay,
    input logic [XW-1:0] bx, input logic [YW-1:0] by,
    input logic [XW-1:0] px, input logic [YW-1:0] py
  );
    e_t dax, day, dbx, dby;
    dax = e_t'($signed({1'b0, ax})) - e_t'($signed({1'b0, px}));
    day = e_t'($signed({1'b0, ay})) - e_t'($signed({1'b0, py}));
    dbx = e_t'($signed({1'b0, bx})) - e_t'($signed({1'b0, px}));
    dby = e_t'($signed({1'b0, by})) - e_t'($signed({1'b0, py}));
    return (dax * dby) - (dbx * day);
  endfunction

  // A zero edge value counts as inside, so shared edges are filled by both triangles.
  function automatic logic edge_ok(input e_t e, input logic area_neg);
    return (e == '0) || (e[EW-1] == area_neg);
  endfunction

  always_comb begin
    xlo = v0x_reg;
    xhi = v0x_reg;
    ylo = v0y_reg;
    yhi = v0y_reg;
    if (v1x_reg < xlo) xlo = v1x_reg;
    if (v2x_reg < xlo) xlo = v2x_reg;
    if (v1x_reg > xhi) xhi = v1x_reg;
    if (v2x_reg > xhi) xhi = v2x_reg;
    if (v1y_reg < ylo) ylo = v1y_reg;
    if (v2y_reg < ylo) ylo = v2y_reg;
    if (v1y_reg > yhi) yhi = v1y_reg;
    if (v2y_reg > yhi) yhi = v2y_reg;
    if (xlo > X_LAST) xlo = X_LAST;
    if (xhi > X_LAST) xhi = X_LAST;
    if (ylo > Y_LAST) ylo = Y_LAST;
    if (yhi > Y_LAST) yhi = Y_LAST;
  end

  always_comb begin
    area = edge_fn(v0x_reg, v0y_reg, v1x_reg, v1y_reg, v2x_reg, v2y_reg);
    e0   = edge_fn(v0x_reg, v0y_reg, v1x_reg, v1y_reg, x_reg, y_reg);
    e1   = edge_fn(v1x_reg, v1y_reg, v2x_reg, v2y_reg, x_reg, y_reg);
    e2   = edge_fn(v2x_reg, v2y_reg, v0x_reg, v0y_reg, x_reg, y_reg);
    pt_inside = edge_ok(e0, area[EW-1]) && edge_ok(e1, area[EW-1]) &&
                edge_ok(e2, area[EW-1]);
  end

  assign at_last = (x_reg == xmax_reg) && (y_reg == ymax_reg);
  assign advance = (state_reg == SCAN) && (!pt_inside || bus.pix_ready);

  always_comb begin
    state_next    = state_reg;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.pix_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) state_next = SETUP;
      end
      SETUP: state_next = (area == '0) ? DONE : SCAN;
      SCAN: begin
        bus.pix_valid = pt_inside;
        if (advance && at_last) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      v0x_reg   <= '0;
      v1x_reg   <= '0;
      v2x_reg   <= '0;
      v0y_reg   <= '0;
      v1y_reg   <= '0;
      v2y_reg   <= '0;
      color_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      xmin_reg  <= '0;
      xmax_reg  <= '0;
      ymax_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            v0x_reg   <= bus.v0x;
            v1x_reg   <= bus.v1x;
            v2x_reg   <= bus.v2x;
            v0y_reg   <= bus.v0y;
            v1y_reg   <= bus.v1y;
            v2y_reg   <= bus.v2y;
            color_reg <= bus.cmd_color;
            count_reg <= '0;
          end
        end
        SETUP: begin
          x_reg    <= xlo;
          y_reg    <= ylo;
          xmin_reg <= xlo;
          xmax_reg <= xhi;
          ymax_reg <= yhi;
        end
        SCAN: begin
          if (advance) begin
            if (pt_inside) count_reg <= count_reg + 1'b1;
            // Hold position on the final candidate so pix_x/pix_y never leave the screen.
            if (!at_last) begin
              if (x_reg == xmax_reg) begin
                x_reg <= xmin_reg;
                y_reg <= y_reg + 1'b1;
              end else begin
                x_reg <= x_reg + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pix_x     = x_reg;
  assign bus.pix_y     = y_reg;
  assign bus.pix_color = color_reg;
  assign bus.pix_count = count_reg;

endmodule

// File: tb/tb_triangle_raster_engine.sv
// Self-checking bench for triangle_raster_engine: directed scenarios plus random
// triangles compared against a plain-arithmetic coverage model.
module tb_triangle_raster_engine;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int CW = 12;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  triangle_raster_engine_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  triangle_raster_engine #(.XW(XW), .YW(YW), .H_RES(H_RES), .V_RES(V_RES), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int exp_x[$];
  int exp_y[$];
  int cap_x[$];
  int cap_y[$];
  int cap_c[$];
  int done_cnt, done_cycle, unstable_cnt, timed_out, final_count, out_of_screen;
  int post_ready, post_busy, post_count;
  int abort_valid, abort_busy, abort_ready, abort_count;

  function automatic longint efn(longint ax, longint ay, longint bx, longint by,
                                 longint px, longint py);
    return (ax - px) * (by - py) - (bx - px) * (ay - py);
  endfunction

  // Reference: every on-screen lattice point covered by the closed triangle, row-major.
  task automatic build_expected(input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2);
    longint a, e0, e1, e2;
    int xa, xb, ya, yb;
    exp_x.delete();
    exp_y.delete();
    a  = efn(x0, y0, x1, y1, x2, y2);
    xa = (x0 < x1) ? x0 : x1;  xa = (x2 < xa) ? x2 : xa;
    xb = (x0 > x1) ? x0 : x1;  xb = (x2 > xb) ? x2 : xb;
    ya = (y0 < y1) ? y0 : y1;  ya = (y2 < ya) ? y2 : ya;
    yb = (y0 > y1) ? y0 : y1;  yb = (y2 > yb) ? y2 : yb;
    if (xb > H_RES - 1) xb = H_RES - 1;
    if (yb > V_RES - 1) yb = V_RES - 1;
    if (a != 0) begin
      for (int y = ya; y <= yb; y++) begin
        for (int x = xa; x <= xb; x++) begin
          e0 = efn(x0, y0, x1, y1, x, y);
          e1 = efn(x1, y1, x2, y2, x, y);
          e2 = efn(x2, y2, x0, y0, x, y);
          if ((e0 == 0 || (e0 > 0) == (a > 0)) && (e1 == 0 || (e1 > 0) == (a > 0)) &&
              (e2 == 0 || (e2 > 0) == (a > 0))) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
          end
        end
      end
    end
  endtask

  // Issues one command and records the pixel stream; mode 0: ready always,
  // 1: ready one cycle in three, 2: random ready. abort_after>0 pulses reset.
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int color, input int mode,
                         input int abort_after);
    int cyc, prev_stall, px, py, pc, xfers, wait_cnt;
    logic rdy;
    cap_x.delete(); cap_y.delete(); cap_c.delete();
    done_cnt = 0; done_cycle = -1; unstable_cnt = 0; timed_out = 0;
    final_count = -1; out_of_screen = 0; xfers = 0; prev_stall = 0;
    px = 0; py = 0; pc = 0;
    wait_cnt = 0;
    while (bus.cmd_ready !== 1'b1 && wait_cnt < 50) begin
      @(posedge clk); #1; wait_cnt++;
    end
    if (wait_cnt >= 50) timed_out = 1;
    bus.v0x = XW'(x0); bus.v0y = YW'(y0);
    bus.v1x = XW'(x1); bus.v1y = YW'(y1);
    bus.v2x = XW'(x2); bus.v2y = YW'(y2);
    bus.cmd_color = CW'(color);
    bus.cmd_valid = 1'b1;
    bus.pix_ready = 1'b0;
    @(posedge clk); #1;
    // Inputs are only sampled at acceptance; scribble over them afterwards.
    bus.v0x = XW'($urandom_range(0, 2047)); bus.v0y = YW'($urandom_range(0, 2047));
    bus.v1x = XW'($urandom_range(0, 2047)); bus.v1y = YW'($urandom_range(0, 2047));
    bus.v2x = XW'($urandom_range(0, 2047)); bus.v2y = YW'($urandom_range(0, 2047));
    bus.cmd_color = CW'($urandom_range(0, 4095));
    cyc = 1;
    while (1) begin
      if (prev_stall != 0) begin
        if (bus.pix_valid !== 1'b1 || int'(bus.pix_x) != px || int'(bus.pix_y) != py ||
            int'(bus.pix_color) != pc)
          unstable_cnt++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = cyc;
        final_count = int'(bus.pix_count);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.pix_ready = rdy;
      bus.cmd_valid = (bus.done === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (bus.pix_valid === 1'b1 && rdy) begin
        cap_x.push_back(int'(bus.pix_x));
        cap_y.push_back(int'(bus.pix_y));
        cap_c.push_back(int'(bus.pix_color));
        xfers++;
        if (int'(bus.pix_x) >= H_RES || int'(bus.pix_y) >= V_RES) out_of_screen++;
      end
      prev_stall = (bus.pix_valid === 1'b1 && !rdy) ? 1 : 0;
      px = int'(bus.pix_x); py = int'(bus.pix_y); pc = int'(bus.pix_color);
      if (bus.done === 1'b1) break;
      if (abort_after > 0 && xfers == abort_after) begin
        @(posedge clk); #1;
        rst_n = 1'b0; bus.pix_ready = 1'b0; bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        abort_valid = int'(bus.pix_valid); abort_busy = int'(bus.busy);
        abort_ready = int'(bus.cmd_ready); abort_count = int'(bus.pix_count);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          if (bus.done === 1'b1 || bus.pix_valid === 1'b1) done_cnt++;
        end
        $display("abort after %0d transfers: valid=%0d busy=%0d ready=%0d count=%0d",
                 xfers, abort_valid, abort_busy, abort_ready, abort_count);
        return;
      end
      if (cyc >= 20000) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    post_ready = int'(bus.cmd_ready);
    post_busy  = int'(bus.busy);
    post_count = int'(bus.pix_count);
    $display("tri (%0d,%0d)(%0d,%0d)(%0d,%0d) mode=%0d pixels=%0d count=%0d done_cycle=%0d",
             x0, y0, x1, y1, x2, y2, mode, cap_x.size(), final_count, done_cycle);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b1; bus.pix_ready = 1'b0;
    bus.v0x = '0; bus.v1x = '0; bus.v2x = '0; bus.v0y = '0; bus.v1y = '0; bus.v2y = '0;
    bus.cmd_color = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b done=%b, required 1 0 0 0",
               bus.cmd_ready, bus.pix_valid, bus.busy, bus.done);
    end
    vectors++;
    if (bus.pix_x !== '0 || bus.pix_y !== '0 || bus.pix_color !== '0 || bus.pix_count !== '0) begin
      miscompares++;
      $display("FAIL reset_data: x=%0d y=%0d c=%0h count=%0d, required all 0",
               bus.pix_x, bus.pix_y, bus.pix_color, bus.pix_count);
    end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset check done");
  endtask

  task automatic test_basic();
    build_expected(10, 10, 20, 10, 10, 20);
    run_cmd(10, 10, 20, 10, 10, 20, 'h00F, 0, 0);
    vectors++;
    if (timed_out != 0 || cap_x.size() != exp_x.size() || cap_x.size() != 66) begin
      miscompares++;
      $display("FAIL t1_len: got %0d pixels (timeout=%0d), required 66", cap_x.size(), timed_out);
    end
    for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++) begin
      vectors++;
      if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != 'h00F) begin
        miscompares++;
        $display("FAIL t1_pix[%0d]: got (%0d,%0d,%0h), required (%0d,%0d,00f)",
                 i, cap_x[i], cap_y[i], cap_c[i], exp_x[i], exp_y[i]);
      end
    end
    vectors++;
    if (cap_x.size() == 0 || cap_x[0] != 10 || cap_y[0] != 10 ||
        cap_x[cap_x.size()-1] != 10 || cap_y[cap_y.size()-1] != 20) begin
      miscompares++;
      $display("FAIL t1_ends: first/last pixel wrong, required (10,10)/(10,20)");
    end
    vectors++;
    if (done_cnt != 1 || done_cycle != 123 || final_count != 66) begin
      miscompares++;
      $display("FAIL t1_done: done_cnt=%0d cycle=%0d count=%0d, required 1 123 66",
               done_cnt, done_cycle, final_count);
    end
    vectors++;
    if (post_ready != 1 || post_busy != 0 || post_count != 66) begin
      miscompares++;
      $display("FAIL t1_idle: ready=%0d busy=%0d count=%0d, required 1 0 66",
               post_ready, post_busy, post_count);
    end
  endtask

  task automatic test_reversed();
    build_expected(10, 10, 20, 10, 10, 20);
    run_cmd(10, 10, 10, 20, 20, 10, 'h0A5, 0, 0);
    vectors++;
    if (timed_out != 0 || cap_x.size() != exp_x.size() || final_count != 66 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL t2_len: got %0d pixels count=%0d done=%0d, required 66 66 1",
               cap_x.size(), final_count, done_cnt);
    end
    for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++) begin
      vectors++;
      if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != 'h0A5) begin
        miscompares++;
        $display("FAIL t2_pix[%0d]: got (%0d,%0d,%0h), required (%0d,%0d,0a5)",
                 i, cap_x[i], cap_y[i], cap_c[i], exp_x[i], exp_y[i]);
      end
    end
  endtask

  task automatic test_collinear();
    run_cmd(0, 0, 5, 5, 10, 10, 'h123, 0, 0);
    vectors++;
    if (timed_out != 0 || cap_x.size() != 0 || done_cycle != 2 || final_count != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL t3_degenerate: pixels=%0d done_cycle=%0d count=%0d done=%0d, required 0 2 0 1",
               cap_x.size(), done_cycle, final_count, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    build_expected(10, 10, 20, 10, 10, 20);
    run_cmd(10, 10, 20, 10, 10, 20, 'h00F, 1, 0);
    vectors++;
    if (timed_out != 0 || cap_x.size() != 66 || final_count != 66 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL t4_len: got %0d pixels count=%0d done=%0d, required 66 66 1",
               cap_x.size(), final_count, done_cnt);
    end
    vectors++;
    if (unstable_cnt != 0) begin
      miscompares++;
      $display("FAIL t4_stable: %0d stalled cycles changed output, required 0", unstable_cnt);
    end
    for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++) begin
      vectors++;
      if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i]) begin
        miscompares++;
        $display("FAIL t4_pix[%0d]: got (%0d,%0d), required (%0d,%0d)",
                 i, cap_x[i], cap_y[i], exp_x[i], exp_y[i]);
      end
    end
  endtask

  task automatic test_clip();
    build_expected(600, 400, 700, 400, 600, 500);
    run_cmd(600, 400, 700, 400, 600, 500, 'hFFF, 0, 0);
    vectors++;
    if (timed_out != 0 || final_count != 3029 || cap_x.size() != exp_x.size() || out_of_screen != 0) begin
      miscompares++;
      $display("FAIL t5_clip: pixels=%0d count=%0d offscreen=%0d, required 3029 3029 0",
               cap_x.size(), final_count, out_of_screen);
    end
    for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++) begin
      if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i]) begin
        vectors++;
        miscompares++;
        $display("FAIL t5_pix[%0d]: got (%0d,%0d), required (%0d,%0d)",
                 i, cap_x[i], cap_y[i], exp_x[i], exp_y[i]);
        break;
      end
    end
  endtask

  task automatic test_reset_abort();
    run_cmd(10, 10, 20, 10, 10, 20, 'h00F, 0, 20);
    vectors++;
    if (abort_valid != 0 || abort_busy != 0 || abort_ready != 1 || abort_count != 0) begin
      miscompares++;
      $display("FAIL t6_abort: valid=%0d busy=%0d ready=%0d count=%0d, required 0 0 1 0",
               abort_valid, abort_busy, abort_ready, abort_count);
    end
    vectors++;
    if (done_cnt != 0 || cap_x.size() != 20) begin
      miscompares++;
      $display("FAIL t6_nodone: stray=%0d transfers=%0d, required 0 20", done_cnt, cap_x.size());
    end
    run_cmd(10, 10, 20, 10, 10, 20, 'h00F, 0, 0);
    vectors++;
    if (timed_out != 0 || done_cnt != 1 || final_count != 66 || cap_x.size() != 66) begin
      miscompares++;
      $display("FAIL t6_resume: done=%0d count=%0d pixels=%0d, required 1 66 66",
               done_cnt, final_count, cap_x.size());
    end
  endtask

  task automatic test_random();
    int v[6];
    int col, bx, by, bad;
    for (int t = 0; t < 8; t++) begin
      bx = int'($urandom_range(0, 700));
      by = int'($urandom_range(0, 520));
      for (int k = 0; k < 3; k++) begin
        v[2*k]   = bx + int'($urandom_range(0, 50)) - 25;
        v[2*k+1] = by + int'($urandom_range(0, 50)) - 25;
        if (v[2*k] < 0) v[2*k] = 0;
        if (v[2*k+1] < 0) v[2*k+1] = 0;
      end
      col = int'($urandom_range(0, 4095));
      build_expected(v[0], v[1], v[2], v[3], v[4], v[5]);
      run_cmd(v[0], v[1], v[2], v[3], v[4], v[5], col, 2, 0);
      vectors++;
      if (timed_out != 0 || done_cnt != 1 || cap_x.size() != exp_x.size() ||
          final_count != exp_x.size() || unstable_cnt != 0) begin
        miscompares++;
        $display("FAIL rand%0d_len: pixels=%0d count=%0d done=%0d unstable=%0d, required %0d %0d 1 0",
                 t, cap_x.size(), final_count, done_cnt, unstable_cnt, exp_x.size(), exp_x.size());
      end
      bad = -1;
      for (int i = 0; i < cap_x.size() && i < exp_x.size(); i++)
        if (bad < 0 && (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != col)) bad = i;
      vectors++;
      if (bad >= 0) begin
        miscompares++;
        $display("FAIL rand%0d_pix[%0d]: got (%0d,%0d,%0h), required (%0d,%0d,%0h)",
                 t, bad, cap_x[bad], cap_y[bad], cap_c[bad], exp_x[bad], exp_y[bad], col);
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.pix_ready = 1'b0;
    test_reset();
    test_basic();
    test_reversed();
    test_collinear();
    test_backpressure();
    test_clip();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
